// File: rtl/button_pkg.sv
// Shared FSM state encoding and width helpers for the push-button edge generator.
package button_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic sync_nreset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_edge_gen.sv
// Debounced push-button to single-cycle advance pulse; define BUTTON_EDGE_GEN_AUTO_REPEAT_EN
// to add hold-to-repeat pulses while the button stays pressed.
module button_edge_gen
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic sync_nreset,
  input  logic button_in,
  output logic next_led_re,
  output logic button_level
);

  localparam int unsigned CNT_W = width_for(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_edge_gen: cycle parameters must be >= 1");
  end

  logic             btn_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             next_led_re_q, next_led_re_d;
  logic             button_level_q, button_level_d;
  logic             press_pulse_c;
  logic             rep_pulse_c;

  sync_2ff u_sync (
    .clk        (clk),
    .sync_nreset(sync_nreset),
    .d          (button_in),
    .q          (btn_sync)
  );

  // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES matching samples.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_pulse_c = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (btn_sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_PRESSED;
          cnt_d         = '0;
          press_pulse_c = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
    next_led_re_d  = press_pulse_c | rep_pulse_c;
    button_level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

`ifdef BUTTON_EDGE_GEN_AUTO_REPEAT_EN
  localparam int unsigned HOLD_W = width_for(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_q, rep_d;

  // Hold timer only runs while PRESSED persists; rep_q selects delay vs period.
  always_comb begin
    hold_d      = '0;
    rep_d       = 1'b0;
    rep_pulse_c = 1'b0;
    if (state_q == ST_PRESSED && state_d == ST_PRESSED) begin
      if (rep_q ? (hold_q == PERIOD_LAST) : (hold_q == DELAY_LAST)) begin
        rep_pulse_c = 1'b1;
        rep_d       = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
        rep_d  = rep_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rep_pulse_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      state_q        <= ST_RELEASED;
      cnt_q          <= '0;
      next_led_re_q  <= 1'b0;
      button_level_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      next_led_re_q  <= next_led_re_d;
      button_level_q <= button_level_d;
    end
  end

  assign next_led_re  = next_led_re_q;
  assign button_level = button_level_q;

endmodule

// File: tb/tb_button_edge_gen.sv
// Scoreboarded bench for button_edge_gen with short debounce/repeat parameters.
module tb_button_edge_gen;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 5;

  logic clk = 1'b0;
  logic sync_nreset;
  logic button_in;
  logic next_led_re;
  logic button_level;

  int n_chk  = 0;
  int n_pass = 0;

  button_edge_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .sync_nreset (sync_nreset),
    .button_in   (button_in),
    .next_led_re (next_led_re),
    .button_level(button_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: level flips once the synchronised input has differed from it
  // for DEB+1 consecutive edges; expectations queued per edge.
  logic [1:0] sb_q[$];
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0;
  int   m_run = 0, m_t = 0;
  int   cyc = 0;

  always @(posedge clk) begin
    logic exp_pulse;
    cyc++;
    exp_pulse = 1'b0;
    if (!sync_nreset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_t = 0;
    end else begin
`ifdef BUTTON_EDGE_GEN_AUTO_REPEAT_EN
      if (m_lvl && m_s2) begin
        if (m_run == 0) begin
          m_t++;
          if (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0)) exp_pulse = 1'b1;
        end else m_t = 0;
      end else m_t = 0;
`endif
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = m_s2; m_run = 0; m_t = 0;
          exp_pulse = m_lvl;
        end
      end else m_run = 0;
      m_s2 = m_s1;
      m_s1 = button_in;
    end
    sb_q.push_back({exp_pulse, m_lvl});
  end

  int pulses = 0, consec = 0, led_idx = 0;
  int last_pulse_cyc = -1, fall_cyc = -1, fall_cnt = 0;
  logic prev_pulse = 1'b0, prev_lvl = 1'b0;

  // Monitor: compare against the scoreboard and record event edges.
  always @(negedge clk) begin
    logic [1:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_pulse", 32'(next_led_re), 32'(e[1]));
      chk("sb_level", 32'(button_level), 32'(e[0]));
    end
    if (next_led_re === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
      led_idx = (led_idx + 1) % 10;
      if (prev_pulse) consec++;
    end
    if (prev_lvl === 1'b1 && button_level === 1'b0) begin
      fall_cyc = cyc;
      fall_cnt++;
    end
    prev_pulse = next_led_re;
    prev_lvl   = button_level;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic v, input int n);
    button_in = v;
    wait_n(n);
  endtask

  initial begin
    int e1, p0, f0;
    sync_nreset = 1'b0;
    button_in   = 1'b0;
    wait_n(3);
    chk("rst_pulse", 32'(next_led_re), 32'd0);
    chk("rst_level", 32'(button_level), 32'd0);
    sync_nreset = 1'b1;
    wait_n(4);

    // Clean press and release
    p0 = pulses; e1 = cyc + 1;
    set_btn(1'b1, 14);
    chk("press_edge", 32'(last_pulse_cyc), 32'(e1 + 6));
    chk("press_cnt", 32'(pulses - p0), 32'd1);
    chk("press_level", 32'(button_level), 32'd1);
    p0 = pulses; e1 = cyc + 1;
    set_btn(1'b0, 12);
    chk("release_edge", 32'(fall_cyc), 32'(e1 + 6));
    chk("release_cnt", 32'(pulses - p0), 32'd0);

    // Bounce before the stable run
    p0 = pulses;
    set_btn(1'b1, 3);
    set_btn(1'b0, 1);
    e1 = cyc + 1;
    set_btn(1'b1, 14);
    chk("bounce_edge", 32'(last_pulse_cyc), 32'(e1 + 6));
    chk("bounce_cnt", 32'(pulses - p0), 32'd1);
    set_btn(1'b0, 12);

    // Release glitch while pressed, then a real second press
    set_btn(1'b1, 14);
    p0 = pulses; f0 = fall_cnt;
    set_btn(1'b0, 2);
    set_btn(1'b1, 8);
    chk("glitch_pulses", 32'(pulses - p0), 32'd0);
    chk("glitch_falls", 32'(fall_cnt - f0), 32'd0);
    chk("glitch_level", 32'(button_level), 32'd1);
    set_btn(1'b0, 12);
    p0 = pulses;
    set_btn(1'b1, 14);
    chk("second_press_cnt", 32'(pulses - p0), 32'd1);
    set_btn(1'b0, 12);

    // Reset in the middle of PRESS_WAIT with the button held
    p0 = pulses;
    set_btn(1'b1, 5);
    sync_nreset = 1'b0;
    wait_n(1);
    chk("midrst_pulse", 32'(next_led_re), 32'd0);
    chk("midrst_level", 32'(button_level), 32'd0);
    chk("midrst_cnt", 32'(pulses - p0), 32'd0);
    e1 = cyc + 1;
    sync_nreset = 1'b1;
    wait_n(14);
    chk("postrst_edge", 32'(last_pulse_cyc), 32'(e1 + 6));
    chk("postrst_cnt", 32'(pulses - p0), 32'd1);
    set_btn(1'b0, 12);

    // Long hold
    p0 = pulses;
    set_btn(1'b1, 34);
`ifdef BUTTON_EDGE_GEN_AUTO_REPEAT_EN
    chk("hold_cnt", 32'(pulses - p0), 32'd5);
`else
    chk("hold_cnt", 32'(pulses - p0), 32'd1);
`endif
    p0 = pulses;
    set_btn(1'b0, 12);
    chk("hold_release_cnt", 32'(pulses - p0), 32'd0);

    // Ten back-to-back presses advance the LED sequence full circle
    p0 = pulses; led_idx = 0;
    for (int i = 0; i < 10; i++) begin
      set_btn(1'b1, 14);
      set_btn(1'b0, 12);
    end
    chk("b2b_cnt", 32'(pulses - p0), 32'd10);
    chk("b2b_led_wrap", 32'(led_idx), 32'd0);
    chk("no_consec_pulse", 32'(consec), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
